// File: rtl/raster_pkg.sv
// Shared definitions for the raster coordinate generator and the projection math block.
package raster_pkg;

  localparam int unsigned COORD_W_DEFAULT = 12;

  // Two-state controller encoding
  typedef logic [0:0] state_t;
  localparam state_t StIdle = 1'b0;
  localparam state_t StRun  = 1'b1;

  function automatic logic ppc_legal(input int unsigned ppc);
    return (ppc == 1) || (ppc == 2) || (ppc == 4);
  endfunction

  // PPC is a power of two, so the width-multiple test is a mask of the low bits
  function automatic logic cfg_legal(input int unsigned width,
                                     input int unsigned height,
                                     input int unsigned ppc,
                                     input int unsigned max_width,
                                     input int unsigned max_height);
    return ppc_legal(ppc) && (width >= ppc) && (width <= max_width) &&
           ((width & (ppc - 1)) == 0) && (height >= 1) && (height <= max_height);
  endfunction

endpackage

// File: rtl/raster_wrap_counter.sv
// Modular counter: load clears to zero and latches the limit, advance steps or wraps.
// at_limit_o is registered alongside the value so downstream flags need no compare.
module raster_wrap_counter #(
  parameter int unsigned Width = 12,
  parameter int unsigned Step  = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [Width-1:0] limit_i,
  output logic [Width-1:0] value_o,
  output logic             at_limit_o
);

  logic [Width-1:0] value_q, value_d;
  logic [Width-1:0] limit_q, limit_d;
  logic             at_limit_q, at_limit_d;
  logic [Width-1:0] step_val;

  assign step_val = value_q + Width'(Step);

  // Next value: load has priority over advance
  always_comb begin
    value_d    = value_q;
    limit_d    = limit_q;
    at_limit_d = at_limit_q;
    if (load_i) begin
      value_d    = '0;
      limit_d    = limit_i;
      at_limit_d = (limit_i == '0);
    end else if (adv_i) begin
      if (at_limit_q) begin
        value_d    = '0;
        at_limit_d = (limit_q == '0);
      end else begin
        value_d    = step_val;
        at_limit_d = (step_val == limit_q);
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      value_q    <= '0;
      limit_q    <= '0;
      at_limit_q <= 1'b0;
    end else begin
      value_q    <= value_d;
      limit_q    <= limit_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign value_o    = value_q;
  assign at_limit_o = at_limit_q;

endmodule

// File: rtl/raster_coord_gen.sv
// Raster coordinate generator: walks a frame in scan order over valid/ready.
// Optional RASTER_FRAME_COUNT_EN adds a 16-bit completed-frame counter output.
module raster_coord_gen
  import raster_pkg::*;
#(
  parameter int unsigned MAX_WIDTH  = 1920,
  parameter int unsigned MAX_HEIGHT = 1080,
  parameter int unsigned PPC        = 1,
  parameter int unsigned COORD_W    = COORD_W_DEFAULT
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [COORD_W-1:0] cfg_width_i,
  input  logic [COORD_W-1:0] cfg_height_i,
  input  logic               continuous_i,
  input  logic               frame_start_i,
  input  logic               abort_i,
  output logic               coord_valid_o,
  input  logic               coord_ready_i,
  output logic [COORD_W-1:0] coord_x_o,
  output logic [COORD_W-1:0] coord_y_o,
  output logic               coord_sof_o,
  output logic               coord_eol_o,
  output logic               coord_eof_o,
  output logic               busy_o,
`ifdef RASTER_FRAME_COUNT_EN
  output logic [15:0]        frame_count_o,
`endif
  output logic               cfg_error_o
);

  state_t state_q, state_d;
  logic   err_q, err_d;
  logic   sof_q, sof_d;
  logic   load, adv, frame_done;
  logic   cfg_ok, xfer;
  logic   x_at_limit, y_at_limit;
  logic   [COORD_W-1:0] x_limit, y_limit;

  assign cfg_ok  = cfg_legal(32'(cfg_width_i), 32'(cfg_height_i), PPC, MAX_WIDTH, MAX_HEIGHT);
  assign x_limit = cfg_width_i - COORD_W'(PPC);
  assign y_limit = cfg_height_i - COORD_W'(1);
  assign xfer    = (state_q == StRun) && coord_ready_i;

  // Controller: abort beats launch and the EOF transfer
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    load       = 1'b0;
    adv        = 1'b0;
    frame_done = 1'b0;
    if (abort_i) begin
      state_d = StIdle;
    end else if (state_q == StIdle) begin
      if (frame_start_i) begin
        if (cfg_ok) begin
          load    = 1'b1;
          err_d   = 1'b0;
          state_d = StRun;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (xfer) begin
      if (x_at_limit && y_at_limit) begin
        frame_done = 1'b1;
        if (continuous_i && cfg_ok) begin
          load  = 1'b1;
          err_d = 1'b0;
        end else begin
          err_d   = err_q | continuous_i;
          state_d = StIdle;
        end
      end else begin
        adv = 1'b1;
      end
    end
  end

  // Start-of-frame flag: set on every launch, cleared by the first transfer
  always_comb begin
    sof_d = sof_q;
    if (load) begin
      sof_d = 1'b1;
    end else if (xfer && !abort_i) begin
      sof_d = 1'b0;
    end
  end

  // Controller state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      sof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      sof_q   <= sof_d;
    end
  end

  raster_wrap_counter #(
    .Width (COORD_W),
    .Step  (PPC)
  ) u_x_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .adv_i      (adv),
    .limit_i    (x_limit),
    .value_o    (coord_x_o),
    .at_limit_o (x_at_limit)
  );

  raster_wrap_counter #(
    .Width (COORD_W),
    .Step  (1)
  ) u_y_cnt (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load),
    .adv_i      (adv && x_at_limit),
    .limit_i    (y_limit),
    .value_o    (coord_y_o),
    .at_limit_o (y_at_limit)
  );

`ifdef RASTER_FRAME_COUNT_EN
  logic [15:0] frame_count_q;

  // Completed-frame counter; wraps naturally at 16 bits
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_count_q <= '0;
    end else if (frame_done) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count_o = frame_count_q;
`endif

  assign coord_valid_o = (state_q == StRun);
  assign busy_o        = (state_q == StRun);
  assign coord_sof_o   = sof_q;
  assign coord_eol_o   = x_at_limit;
  assign coord_eof_o   = x_at_limit && y_at_limit;
  assign cfg_error_o   = err_q;

endmodule

// File: tb/tb_raster_coord_gen.sv
// Bench for raster_coord_gen: a PPC=1 and a PPC=2 instance share every input
// except the launch pulse; a scoreboard queue holds the expected beats.
module tb_raster_coord_gen;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
    logic        eol;
    logic        eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] cfg_width = '0;
  logic [11:0] cfg_height = '0;
  logic        continuous = 1'b0;
  logic        start1 = 1'b0;
  logic        start2 = 1'b0;
  logic        abort = 1'b0;
  logic        ready = 1'b1;

  logic        v1, b1, sof1, eol1, eof1, err1;
  logic        v2, b2, sof2, eol2, eof2, err2;
  logic [11:0] x1, y1, x2, y2;
`ifdef RASTER_FRAME_COUNT_EN
  logic [15:0] fc1, fc2;
`endif

  int    vectors = 0;
  int    miscompares = 0;
  int    beats_seen = 0;
  bit    sel = 1'b0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  raster_coord_gen #(.PPC(1)) u_dut1 (
    .clk_i (clk), .reset_i (reset), .cfg_width_i (cfg_width), .cfg_height_i (cfg_height),
    .continuous_i (continuous), .frame_start_i (start1), .abort_i (abort),
    .coord_valid_o (v1), .coord_ready_i (ready), .coord_x_o (x1), .coord_y_o (y1),
    .coord_sof_o (sof1), .coord_eol_o (eol1), .coord_eof_o (eof1), .busy_o (b1),
`ifdef RASTER_FRAME_COUNT_EN
    .frame_count_o (fc1),
`endif
    .cfg_error_o (err1)
  );

  raster_coord_gen #(.PPC(2)) u_dut2 (
    .clk_i (clk), .reset_i (reset), .cfg_width_i (cfg_width), .cfg_height_i (cfg_height),
    .continuous_i (continuous), .frame_start_i (start2), .abort_i (abort),
    .coord_valid_o (v2), .coord_ready_i (ready), .coord_x_o (x2), .coord_y_o (y2),
    .coord_sof_o (sof2), .coord_eol_o (eol2), .coord_eof_o (eof2), .busy_o (b2),
`ifdef RASTER_FRAME_COUNT_EN
    .frame_count_o (fc2),
`endif
    .cfg_error_o (err2)
  );

  // Scoreboard: every handshake on the selected instance pops one expected beat
  always @(negedge clk) begin
    logic        mv, ms, ml, mf;
    logic [11:0] mx, my;
    beat_t       e;
    mv = sel ? v2 : v1;
    mx = sel ? x2 : x1;
    my = sel ? y2 : y1;
    ms = sel ? sof2 : sof1;
    ml = sel ? eol2 : eol1;
    mf = sel ? eof2 : eof1;
    if (!reset && mv && ready) begin
      beats_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: got x=%0d y=%0d, expected no beat", mx, my);
      end else begin
        e = exp_q.pop_front();
        if ({mx, my, ms, ml, mf} !== {e.x, e.y, e.sof, e.eol, e.eof})
        begin
          miscompares++;
          $display("FAIL beat: got x=%0d y=%0d sof=%b eol=%b eof=%b, expected x=%0d y=%0d sof=%b eol=%b eof=%b",
                   mx, my, ms, ml, mf, e.x, e.y, e.sof, e.eol, e.eof);
        end
      end
    end
  end

  // Reference model of scan order
  task automatic push_frame(input int ppc, input int w, input int h);
    beat_t b;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx += ppc) begin
        b.x   = 12'(xx);
        b.y   = 12'(yy);
        b.sof = (xx == 0) && (yy == 0);
        b.eol = (xx == w - ppc);
        b.eof = (xx == w - ppc) && (yy == h - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  // Pulse frame_start for one cycle; returns one #1 after the accepting edge
  task automatic launch(input bit which, input int w, input int h);
    @(posedge clk);
    #1;
    cfg_width  = 12'(w);
    cfg_height = 12'(h);
    beats_seen = 0;
    if (which) start2 = 1'b1;
    else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({v1, b1, err1, x1, y1, sof1, eol1, eof1} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut1: got v=%b busy=%b err=%b x=%0d y=%0d, expected all zero",
               v1, b1, err1, x1, y1);
    end
    vectors++;
    if ({v2, b2, err2, x2, y2, sof2, eol2, eof2} !== '0) begin
      miscompares++;
      $display("FAIL reset_dut2: got v=%b busy=%b err=%b x=%0d y=%0d, expected all zero",
               v2, b2, err2, x2, y2);
    end
`ifdef RASTER_FRAME_COUNT_EN
    vectors++;
    if (fc1 !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_frame_count: got %0d, expected 0", fc1);
    end
`endif
    #1 reset = 1'b0;
  endtask

  task automatic test_single(input bit which, input int ppc, input int w, input int h);
    sel = which;
    push_frame(ppc, w, h);
    launch(which, w, h);
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL single_drain ppc=%0d: %0d beats outstanding, expected 0", ppc, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    vectors++;
    if ((which ? v2 : v1) !== 1'b0) begin
      miscompares++;
      $display("FAIL single_valid_after_eof ppc=%0d: got 1, expected 0", ppc);
    end
    vectors++;
    if (beats_seen != (w / ppc) * h) begin
      miscompares++;
      $display("FAIL single_beat_count ppc=%0d: got %0d, expected %0d", ppc, beats_seen,
               (w / ppc) * h);
    end
  endtask

  task automatic test_stall();
    logic [3:0]  pat = 4'b1001;
    logic [23:0] held = '0;
    bit          stalled = 1'b0;
    sel = 1'b0;
    push_frame(1, 4, 1);
    launch(1'b0, 4, 1);
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
      ready = pat[c % 4];
      @(negedge clk);
      if (stalled) begin
        vectors++;
        if ({x1, y1} !== held) begin
          miscompares++;
          $display("FAIL stall_hold: got x=%0d y=%0d, expected x=%0d y=%0d", x1, y1,
                   held[23:12], held[11:0]);
        end
      end
      stalled = v1 && !ready;
      held    = {x1, y1};
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    vectors++;
    if (exp_q.size() != 0 || beats_seen != 4) begin
      miscompares++;
      $display("FAIL stall_transfers: got %0d transfers, expected 4", beats_seen);
      exp_q.delete();
    end
  endtask

  task automatic test_illegal();
    bit which_t[3] = '{1'b1, 1'b0, 1'b0};
    int w_t[3]     = '{7, 0, 4};
    int h_t[3]     = '{1, 1, 2000};
    for (int i = 0; i < 3; i++) begin
      launch(which_t[i], w_t[i], h_t[i]);
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vectors++;
        if ((which_t[i] ? {v2, b2} : {v1, b1}) !== 2'b00) begin
          miscompares++;
          $display("FAIL illegal_%0d_valid_busy: got nonzero, expected 0", i);
        end
      end
      vectors++;
      if ((which_t[i] ? err2 : err1) !== 1'b1) begin
        miscompares++;
        $display("FAIL illegal_%0d_cfg_error: got 0, expected 1", i);
      end
    end
    // A following legal launch clears the sticky error
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      push_frame(d + 1, 4, 1);
      launch(d[0], 4, 1);
      @(negedge clk);
      vectors++;
      if ((d[0] ? err2 : err1) !== 1'b0) begin
        miscompares++;
        $display("FAIL legal_clears_error dut%0d: got 1, expected 0", d + 1);
      end
      for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
        miscompares++;
        $display("FAIL legal_drain dut%0d: %0d outstanding, expected 0", d + 1, exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic test_continuous();
    logic [15:0] fc0 = '0;
`ifdef RASTER_FRAME_COUNT_EN
    fc0 = fc1;
`endif
    sel = 1'b0;
    continuous = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(1, 4, 2);
    launch(1'b0, 4, 2);
    for (int c = 0; c < 100; c++) begin
      if (exp_q.size() == 0) break;
      if (beats_seen >= 16) continuous = 1'b0;
      @(negedge clk);
      vectors++;
      if (v1 !== 1'b1) begin
        miscompares++;
        $display("FAIL continuous_no_bubble: got valid=0 after %0d beats, expected 1",
                 beats_seen);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    vectors++;
    if (v1 !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL continuous_end: got valid=%b outstanding=%0d, expected 0 and 0", v1,
               exp_q.size());
      exp_q.delete();
    end
`ifdef RASTER_FRAME_COUNT_EN
    vectors++;
    if (fc1 !== fc0 + 16'd3) begin
      miscompares++;
      $display("FAIL continuous_frame_count: got %0d, expected %0d", fc1, fc0 + 16'd3);
    end
`endif
    continuous = 1'b0;
  endtask

  task automatic test_abort();
    logic [15:0] fc0 = '0;
`ifdef RASTER_FRAME_COUNT_EN
    fc0 = fc1;
`endif
    sel = 1'b0;
    push_frame(1, 8, 4);
    while (exp_q.size() > 11) void'(exp_q.pop_back());
    launch(1'b0, 8, 4);
    for (int c = 0; c < 50 && beats_seen < 10; c++) begin
      @(posedge clk);
      #1;
    end
    abort = 1'b1;
    @(negedge clk);
    vectors++;
    if ({v1, x1, y1} !== {1'b1, 12'd2, 12'd1}) begin
      miscompares++;
      $display("FAIL abort_beat: got v=%b x=%0d y=%0d, expected v=1 x=2 y=1", v1, x1, y1);
    end
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    vectors++;
    if ({v1, b1} !== 2'b00 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_idle: got v=%b busy=%b outstanding=%0d, expected 0 0 0", v1, b1,
               exp_q.size());
      exp_q.delete();
    end
`ifdef RASTER_FRAME_COUNT_EN
    vectors++;
    if (fc1 !== fc0) begin
      miscompares++;
      $display("FAIL abort_frame_count: got %0d, expected %0d", fc1, fc0);
    end
`endif
    // Restart after abort begins again at (0,0)
    push_frame(1, 4, 1);
    launch(1'b0, 4, 1);
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_restart: %0d outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single(1'b0, 1, 8, 2);
    test_single(1'b1, 2, 6, 3);
    test_stall();
    test_illegal();
    test_continuous();
    test_abort();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
